count_display: RTL and testbench
================================

COUNT_DISPLAY -- requirements
Module: count_display

Interface
REQ-001 Parameter REFRESH_DIV, default 50000, clk cycles per digit-scan step (>=2).
REQ-002 Parameter STRETCH, default 25000000, clk cycles led_flag stays high after flag drops (>=1).
REQ-003 The block SHALL have one clock and a synchronous active-low reset; clock and reset ports are clk and rst_n.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 count  in  8  binary value from the up/down counter stage, unsigned.
REQ-007 flag  in  1  counter-stage flag, high while count==30.
REQ-008 zero  in  1  counter-stage zero indication.
REQ-009 seg  out  7  {g,f,e,d,c,b,a}, active-low, registered.
REQ-010 an  out  4  digit enables, active-low, one-hot-low, registered.
REQ-011 busy  out  1  high while a conversion is in progress.
REQ-012 led_flag  out  1  stretched flag indicator, registered.
REQ-013 led_zero  out  1  zero delayed one cycle, registered.

Function
REQ-014 Converter FSM states: IDLE, CONV, LOAD; reset state IDLE.
REQ-015 IDLE -> CONV at an edge where count != last_val or valid==0; that edge captures count into a shift register, clears the step counter, and zeroes the BCD accumulator.
REQ-016 CONV: one double-dabble step per cycle (add 3 to any BCD nibble >=5, then shift left 1); after the 8th step -> LOAD.
REQ-017 LOAD: one cycle; writes hundreds/tens/ones to the display register, sets last_val to the captured value and valid=1, -> IDLE.
REQ-018 Latency: count change sampled at edge k; display register updated at edge k+9; busy high from edge k through edge k+9 exclusive (CONV and LOAD states).
REQ-019 count changes while busy are ignored; on return to IDLE the compare re-detects the difference and starts a new conversion.
REQ-020 BCD accumulator 10 bits (hundreds 2b, tens 4b, ones 4b); 255 SHALL produce 2/5/5, no overflow.
REQ-021 Scan divider counts 0..REFRESH_DIV-1 and wraps; on wrap, digit select advances 0->1->2->3->0.
REQ-022 Digit 0 = ones, 1 = tens, 2 = hundreds, 3 = always blank.
REQ-023 Leading-zero blanking: hundreds blank when 0; tens blank when hundreds==0 and tens==0; ones never blank.
REQ-024 Segment codes 0-9 are the standard active-low set (0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000); blank=1111111.
REQ-025 seg and an update on the same edge as the digit select, so they never mismatch.
REQ-026 Stretch counter loads STRETCH-1 every cycle flag==1 and otherwise decrements to 0; led_flag = (flag==1) or (counter!=0), registered.
REQ-027 flag and a new conversion on the same cycle are independent; neither delays the other.

Reset
REQ-028 On rst_n==0 at an edge: FSM=IDLE, valid=0, last_val=0, display register=0, divider=0, digit select=0, stretch counter=0.
REQ-029 Reset outputs: seg=1111111, an=1111, busy=0, led_flag=0, led_zero=0.
REQ-030 Reset mid-conversion SHALL abort it without updating the display; the first cycle after release starts a fresh conversion (valid==0).

Structure
REQ-031 Shared package holds the FSM state enum, the 10 segment codes plus the blank code, and the digit-count constant (4).
REQ-032 Sub-module bin2bcd_serial implements REQ-015..REQ-020 (start/busy/done, 8-bit in, 10-bit BCD out); the top module holds the scan, blanking, and stretch logic.

Verification
REQ-033 Reset held 3 cycles -> seg=1111111, an=1111, busy=0, led_flag=0; release with count=0 -> busy for 9 cycles, then digit 0 shows 1000000, digits 1-3 blank.
REQ-034 count=60 stable -> display register 0/6/0 at edge k+9; scan shows digit0=1000000, digit1=0000010, digit2=blank, digit3=blank.
REQ-035 count=255 -> 2/5/5, all three digits lit; count=7 -> only digit 0 lit (1111000).
REQ-036 count 10->11 at busy edge k+3 -> first result 10, then a second conversion starts automatically and yields 11.
REQ-037 flag high 1 cycle, STRETCH=4 -> led_flag high exactly 4 consecutive cycles, starting the cycle after flag.
REQ-038 rst_n low at CONV step 4 -> display unchanged (0), busy=0; after release, conversion of the current count completes in 9 cycles.

Source files
------------

// File: rtl/count_display_pkg.sv
// Shared types and constants for the count display: converter states,
// active-low seven-segment codes {g,f,e,d,c,b,a} and the digit count.
package count_display_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } conv_state_e;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_encode = SEG_0;
      4'd1:    seg_encode = SEG_1;
      4'd2:    seg_encode = SEG_2;
      4'd3:    seg_encode = SEG_3;
      4'd4:    seg_encode = SEG_4;
      4'd5:    seg_encode = SEG_5;
      4'd6:    seg_encode = SEG_6;
      4'd7:    seg_encode = SEG_7;
      4'd8:    seg_encode = SEG_8;
      4'd9:    seg_encode = SEG_9;
      default: seg_encode = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble converter: restarts whenever the input differs from
// the last converted value, 8 shift steps then a one-cycle LOAD (done_o).
module bin2bcd_serial
  import count_display_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] bin_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [9:0] bcd_o
);

  conv_state_e state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  cap_q, cap_d;
  logic [7:0]  last_q, last_d;
  logic        valid_q, valid_d;
  logic [9:0]  acc_q, acc_d;
  logic [2:0]  step_q, step_d;
  logic [9:0]  adj;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cap_q   <= '0;
      last_q  <= '0;
      valid_q <= 1'b0;
      acc_q   <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cap_q   <= cap_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cap_d   = cap_q;
    last_d  = last_q;
    valid_d = valid_q;
    acc_d   = acc_q;
    step_d  = step_q;
    adj     = acc_q;
    case (state_q)
      IDLE: begin
        if (!valid_q || (bin_i != last_q)) begin
          state_d = CONV;
          shift_d = bin_i;
          cap_d   = bin_i;
          step_d  = '0;
          acc_d   = '0;
        end
      end
      CONV: begin
        // Hundreds never reaches 5 before the final shift, so only two nibbles need adjusting.
        if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
        if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;
        acc_d   = {adj[8:0], shift_q[7]};
        shift_d = {shift_q[6:0], 1'b0};
        step_d  = step_q + 3'd1;
        if (step_q == 3'd7) state_d = LOAD;
      end
      LOAD: begin
        last_d  = cap_q;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == LOAD);
  assign bcd_o  = acc_q;

endmodule

// File: rtl/count_display.sv
// Four-digit multiplexed display of an 8-bit count with leading-zero
// blanking, plus a pulse-stretched flag LED and a delayed zero LED.
module count_display
  import count_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int STRETCH     = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] count,
  input  logic       flag,
  input  logic       zero,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       busy,
  output logic       led_flag,
  output logic       led_zero
);

  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int STR_W = $clog2(STRETCH + 1);
  localparam int SEL_W = $clog2(NUM_DIGITS);

  logic                  conv_done;
  logic [9:0]            conv_bcd;
  logic [9:0]            display_q, display_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [STR_W-1:0]      str_q, str_d;
  logic                  led_flag_q, led_flag_d;
  logic                  led_zero_q;
  logic [1:0]            hundreds;
  logic [3:0]            tens, ones;

  bin2bcd_serial u_conv (
    .clk    (clk),
    .rst_n  (rst_n),
    .bin_i  (count),
    .busy_o (busy),
    .done_o (conv_done),
    .bcd_o  (conv_bcd)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      display_q  <= '0;
      div_q      <= '0;
      sel_q      <= '0;
      seg_q      <= SEG_BLANK;
      an_q       <= '1;
      str_q      <= '0;
      led_flag_q <= 1'b0;
      led_zero_q <= 1'b0;
    end else begin
      display_q  <= display_d;
      div_q      <= div_d;
      sel_q      <= sel_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      str_q      <= str_d;
      led_flag_q <= led_flag_d;
      led_zero_q <= zero;
    end
  end

  assign hundreds = display_q[9:8];
  assign tens     = display_q[7:4];
  assign ones     = display_q[3:0];

  always_comb begin
    display_d = conv_done ? conv_bcd : display_q;
    div_d     = div_q + 1'b1;
    sel_d     = sel_q;
    if (div_q == DIV_W'(REFRESH_DIV - 1)) begin
      div_d = '0;
      sel_d = sel_q + 1'b1;
    end
    // seg/an are built from the next select so all three change on one edge.
    an_d = ~(NUM_DIGITS'(1) << sel_d);
    case (sel_d)
      2'd0:    seg_d = seg_encode(ones);
      2'd1:    seg_d = (hundreds == 2'd0 && tens == 4'd0) ? SEG_BLANK : seg_encode(tens);
      2'd2:    seg_d = (hundreds == 2'd0) ? SEG_BLANK : seg_encode({2'b00, hundreds});
      default: seg_d = SEG_BLANK;
    endcase
    if (flag)             str_d = STR_W'(STRETCH - 1);
    else if (str_q != '0) str_d = str_q - 1'b1;
    else                  str_d = str_q;
    led_flag_d = flag | (str_q != '0);
  end

  assign seg      = seg_q;
  assign an       = an_q;
  assign led_flag = led_flag_q;
  assign led_zero = led_zero_q;

endmodule

// File: tb/tb_count_display.sv
// Randomized self-checking bench for count_display against a decimal
// arithmetic reference model of conversion timing, scan output and LEDs.
module tb_count_display;

  localparam int REFRESH_DIV = 3;
  localparam int STRETCH     = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] count = 8'd0;
  logic       flag = 1'b0;
  logic       zero = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       busy;
  logic       led_flag;
  logic       led_zero;

  int tests = 0;
  int fails = 0;
  int model_last = -1;

  count_display #(.REFRESH_DIV(REFRESH_DIV), .STRETCH(STRETCH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .count    (count),
    .flag     (flag),
    .zero     (zero),
    .seg      (seg),
    .an       (an),
    .busy     (busy),
    .led_flag (led_flag),
    .led_zero (led_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] code(input int d);
    case (d)
      0: code = 7'b1000000;
      1: code = 7'b1111001;
      2: code = 7'b0100100;
      3: code = 7'b0110000;
      4: code = 7'b0011001;
      5: code = 7'b0010010;
      6: code = 7'b0000010;
      7: code = 7'b1111000;
      8: code = 7'b0000000;
      9: code = 7'b0010000;
      default: code = 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] digit_seg(input int v, input int d);
    case (d)
      0: digit_seg = code(v % 10);
      1: digit_seg = (v >= 10) ? code((v / 10) % 10) : 7'b1111111;
      2: digit_seg = (v >= 100) ? code(v / 100) : 7'b1111111;
      default: digit_seg = 7'b1111111;
    endcase
  endfunction

  function automatic logic [9:0] bcd_of(input int v);
    bcd_of = 10'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
  endfunction

  // Apply a value (also releases reset) and check busy over the 10 following edges.
  task automatic conv_run(input int v);
    logic expect_conv;
    logic exp_b;
    expect_conv = (v != model_last);
    @(negedge clk);
    count = 8'(v);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      exp_b = expect_conv && (i < 9);
      tests++;
      if (busy !== exp_b) begin
        fails++;
        $display("FAIL busy_timing v=%0d edge+%0d got=%b exp=%b", v, i, busy, exp_b);
      end
    end
    model_last = v;
    tests++;
    if (dut.display_q !== bcd_of(v)) begin
      fails++;
      $display("FAIL display_reg v=%0d got=%h exp=%h", v, dut.display_q, bcd_of(v));
    end
    $display("[TB] conv value=%0d started=%b", v, expect_conv);
  endtask

  task automatic scan_check(input int v);
    logic [3:0] exp_an;
    int n;
    @(posedge clk); #1;
    for (int d = 0; d < 4; d++) begin
      exp_an = 4'b1111 ^ (4'b0001 << d);
      n = 0;
      while (an !== exp_an && n < 40) begin
        @(posedge clk); #1;
        n++;
      end
      tests++;
      if (an !== exp_an || seg !== digit_seg(v, d)) begin
        fails++;
        $display("FAIL scan v=%0d digit=%0d an=%b seg=%b exp_an=%b exp_seg=%b",
                 v, d, an, seg, exp_an, digit_seg(v, d));
      end
    end
    $display("[TB] scan value=%0d checked", v);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    count = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    tests += 5;
    if (seg !== 7'b1111111) begin fails++; $display("FAIL reset_seg got=%b exp=1111111", seg); end
    if (an !== 4'b1111) begin fails++; $display("FAIL reset_an got=%b exp=1111", an); end
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (led_flag !== 1'b0) begin fails++; $display("FAIL reset_led_flag got=%b exp=0", led_flag); end
    if (led_zero !== 1'b0) begin fails++; $display("FAIL reset_led_zero got=%b exp=0", led_zero); end
    $display("[TB] reset outputs checked");
    model_last = -1;
    conv_run(0);
    scan_check(0);
  endtask

  task automatic test_values();
    conv_run(60);  scan_check(60);
    conv_run(255); scan_check(255);
    conv_run(7);   scan_check(7);
    conv_run(7);   scan_check(7);
  endtask

  task automatic test_random();
    int v;
    for (int t = 0; t < 10; t++) begin
      v = ($urandom % 4 == 0) ? model_last : int'($urandom_range(0, 255));
      conv_run(v);
      scan_check(v);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_b;
    conv_run(200);
    @(negedge clk);
    count = 8'd10;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      exp_b = (i <= 8) || (i >= 10 && i <= 18);
      tests++;
      if (busy !== exp_b) begin
        fails++;
        $display("FAIL b2b_busy edge+%0d got=%b exp=%b", i, busy, exp_b);
      end
      if (i == 9) begin
        tests++;
        if (dut.display_q !== bcd_of(10)) begin
          fails++;
          $display("FAIL b2b_first got=%h exp=%h", dut.display_q, bcd_of(10));
        end
      end
      if (i == 2) begin
        @(negedge clk);
        count = 8'd11;
      end
    end
    tests++;
    if (dut.display_q !== bcd_of(11)) begin
      fails++;
      $display("FAIL b2b_second got=%h exp=%h", dut.display_q, bcd_of(11));
    end
    model_last = 11;
    $display("[TB] back_to_back 10->11 checked");
    scan_check(11);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    count = 8'd45;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    tests += 4;
    if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    if (seg !== 7'b1111111) begin fails++; $display("FAIL midrst_seg got=%b exp=1111111", seg); end
    if (an !== 4'b1111) begin fails++; $display("FAIL midrst_an got=%b exp=1111", an); end
    if (dut.display_q !== 10'd0) begin fails++; $display("FAIL midrst_display got=%h exp=000", dut.display_q); end
    $display("[TB] mid-conversion reset checked");
    model_last = -1;
    conv_run(45);
    scan_check(45);
  endtask

  task automatic test_stretch();
    logic h1, h2, h3, exp_f;
    h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i == 0)     flag = 1'b1;
      else if (i < 8) flag = 1'b0;
      else            flag = ($urandom % 5 == 0);
      zero = 1'($urandom % 2);
      @(posedge clk); #1;
      exp_f = flag | h1 | h2 | h3;
      tests += 2;
      if (led_flag !== exp_f) begin
        fails++;
        $display("FAIL led_flag cycle=%0d got=%b exp=%b", i, led_flag, exp_f);
      end
      if (led_zero !== zero) begin
        fails++;
        $display("FAIL led_zero cycle=%0d got=%b exp=%b", i, led_zero, zero);
      end
      $display("[TB] stretch cycle=%0d flag=%b led_flag=%b", i, flag, led_flag);
      h3 = h2; h2 = h1; h1 = flag;
    end
    @(negedge clk);
    flag = 1'b0;
    zero = 1'b0;
  endtask

  initial begin
    test_reset();
    test_values();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_stretch();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
